// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types for the memory arbiter.
//   state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   owner_e : which requester currently owns the memory controller
//   len_e   : access length codes (BYTE=0, HALF=1, WORD=3)
//   addr_t / word_t : 32-bit address and data words
package mem_arb_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LB   = 2'd2,
    OWN_ST   = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    LEN_BYTE = 2'd0,
    LEN_HALF = 2'd1,
    LEN_WORD = 2'd3
  } len_e;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr -- two-way round-robin picker (purely combinational).
//   req_a, req_b     : qualified requests
//   last_b           : 1 when b was the most recent grant
//   grant_a, grant_b : one-hot (or zero) grant; on a tie the side not
//                      granted last wins
module mem_arb_rr (
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  output logic grant_a,
  output logic grant_b
);

  always_comb begin
    grant_a = req_a && (!req_b || last_b);
    grant_b = req_b && (!req_a || !last_b);
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb -- arbitrates instruction fetch (IF), load (LB) and store (ST)
// requests onto a single memory controller, one request outstanding.
//   clk, rst (async, active-high), rdy (low freezes everything)
//   clear_flag_in   : pipeline flush; forwarded as mc_clear_out, deferred
//                     until an owned store has completed
//   if_* / lb_* / st_* : level requests in, one-cycle done pulses out
//   mc_*_en_out     : one-cycle issue pulse to the memory controller
//   mc_addr/len/data_out : latched request fields, stable until done
//   mc_*_done_in, mc_data_in : memory controller completions
//   timeout_err_out : sticky, set once WAIT lasts TIMEOUT_CYC cycles
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear_flag_in,
  input  logic        if_req_in,
  input  addr_t       if_addr_in,
  input  logic        lb_req_in,
  input  addr_t       lb_addr_in,
  input  logic [1:0]  lb_len_in,
  input  logic        st_req_in,
  input  addr_t       st_addr_in,
  input  logic [1:0]  st_len_in,
  input  word_t       st_data_in,
  output logic        if_done_out,
  output word_t       if_data_out,
  output logic        lb_done_out,
  output word_t       lb_data_out,
  output logic        st_done_out,
  output logic        mc_if_en_out,
  output logic        mc_lb_en_out,
  output logic        mc_st_en_out,
  output addr_t       mc_addr_out,
  output logic [1:0]  mc_len_out,
  output word_t       mc_data_out,
  output logic        mc_clear_out,
  input  logic        mc_if_done_in,
  input  logic        mc_lb_done_in,
  input  logic        mc_st_done_in,
  input  word_t       mc_data_in,
  output logic        timeout_err_out
);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             last_lb_q, last_lb_d;
  logic             clear_pend_q, clear_pend_d;
  logic             clear_fwd_q, clear_fwd_d;
  logic             if_drop_q, if_drop_d;
  logic             lb_drop_q, lb_drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  addr_t            mc_addr_q, mc_addr_d;
  logic [1:0]       mc_len_q, mc_len_d;
  word_t            mc_data_q, mc_data_d;
  logic             mc_if_en_q, mc_if_en_d;
  logic             mc_lb_en_q, mc_lb_en_d;
  logic             mc_st_en_q, mc_st_en_d;
  logic             if_done_q, if_done_d;
  logic             lb_done_q, lb_done_d;
  logic             st_done_q, st_done_d;
  word_t            if_data_q, if_data_d;
  word_t            lb_data_q, lb_data_d;

  logic st_owned, flush;
  logic if_ok, lb_ok, st_ok;
  logic grant_if, grant_lb;

  // A clear is deferred while a store owns the controller; a deferred clear
  // later re-enters as clear_fwd_q and flushes just like a direct one.
  assign st_owned = (owner_q == OWN_ST) && (state_q != S_IDLE);
  assign flush    = (clear_flag_in && !st_owned) || clear_fwd_q;

  // Requests are levels held until done; mask a requester during its own
  // done pulse so the still-high level is not granted a second time.
  assign if_ok = if_req_in && !if_drop_q && !if_done_q;
  assign lb_ok = lb_req_in && !lb_drop_q && !lb_done_q;
  assign st_ok = st_req_in && !st_done_q;

  mem_arb_rr u_rr (
    .req_a   (if_ok),
    .req_b   (lb_ok),
    .last_b  (last_lb_q),
    .grant_a (grant_if),
    .grant_b (grant_lb)
  );

  always_comb begin
    // NOTE: every _d starts from its _q (pulses from 0) so no branch can
    // leave a variable unassigned and infer a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    last_lb_d     = last_lb_q;
    clear_pend_d  = clear_pend_q;
    clear_fwd_d   = 1'b0;
    if_drop_d     = if_drop_q && if_req_in;
    lb_drop_d     = lb_drop_q && lb_req_in;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    mc_addr_d     = mc_addr_q;
    mc_len_d      = mc_len_q;
    mc_data_d     = mc_data_q;
    mc_if_en_d    = 1'b0;
    mc_lb_en_d    = 1'b0;
    mc_st_en_d    = 1'b0;
    if_done_d     = 1'b0;
    lb_done_d     = 1'b0;
    st_done_d     = 1'b0;
    if_data_d     = if_data_q;
    lb_data_d     = lb_data_q;

    if (flush) begin
      // Flush beats any same-cycle grant or completion; pending IF/LB levels
      // are ignored until their requester drops and re-raises them.
      state_d   = S_IDLE;
      owner_d   = OWN_NONE;
      if_drop_d = 1'b1;
      lb_drop_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!clear_pend_q) begin
            if (st_ok) begin
              owner_d    = OWN_ST;
              mc_addr_d  = st_addr_in;
              mc_len_d   = st_len_in;
              mc_data_d  = st_data_in;
              mc_st_en_d = 1'b1;
              state_d    = S_ISSUE;
            end else if (grant_if) begin
              owner_d    = OWN_IF;
              mc_addr_d  = if_addr_in;
              mc_len_d   = LEN_WORD;
              mc_data_d  = '0;
              mc_if_en_d = 1'b1;
              last_lb_d  = 1'b0;
              state_d    = S_ISSUE;
            end else if (grant_lb) begin
              owner_d    = OWN_LB;
              mc_addr_d  = lb_addr_in;
              mc_len_d   = lb_len_in;
              mc_data_d  = '0;
              mc_lb_en_d = 1'b1;
              last_lb_d  = 1'b1;
              state_d    = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 8'd1;
          if (cnt_d >= TIMEOUT_CYC) timeout_err_d = 1'b1;
          if ((owner_q == OWN_IF) && mc_if_done_in) begin
            if_done_d = 1'b1;
            if_data_d = mc_data_in;
            owner_d   = OWN_NONE;
            state_d   = S_IDLE;
          end else if ((owner_q == OWN_LB) && mc_lb_done_in) begin
            lb_done_d = 1'b1;
            lb_data_d = mc_data_in;
            owner_d   = OWN_NONE;
            state_d   = S_IDLE;
          end else if ((owner_q == OWN_ST) && mc_st_done_in) begin
            st_done_d = 1'b1;
            owner_d   = OWN_NONE;
            state_d   = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      endcase
    end

    if (clear_flag_in && st_owned) clear_pend_d = 1'b1;
    // Forward the deferred clear the cycle after st_done_out.
    if (clear_pend_q && st_done_q) begin
      clear_pend_d = 1'b0;
      clear_fwd_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_NONE;
      last_lb_q     <= 1'b1;  // IF wins the first tie
      clear_pend_q  <= 1'b0;
      clear_fwd_q   <= 1'b0;
      if_drop_q     <= 1'b0;
      lb_drop_q     <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      mc_addr_q     <= '0;
      mc_len_q      <= '0;
      mc_data_q     <= '0;
      mc_if_en_q    <= 1'b0;
      mc_lb_en_q    <= 1'b0;
      mc_st_en_q    <= 1'b0;
      if_done_q     <= 1'b0;
      lb_done_q     <= 1'b0;
      st_done_q     <= 1'b0;
      if_data_q     <= '0;
      lb_data_q     <= '0;
    end else if (rdy) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_lb_q     <= last_lb_d;
      clear_pend_q  <= clear_pend_d;
      clear_fwd_q   <= clear_fwd_d;
      if_drop_q     <= if_drop_d;
      lb_drop_q     <= lb_drop_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      mc_addr_q     <= mc_addr_d;
      mc_len_q      <= mc_len_d;
      mc_data_q     <= mc_data_d;
      mc_if_en_q    <= mc_if_en_d;
      mc_lb_en_q    <= mc_lb_en_d;
      mc_st_en_q    <= mc_st_en_d;
      if_done_q     <= if_done_d;
      lb_done_q     <= lb_done_d;
      st_done_q     <= st_done_d;
      if_data_q     <= if_data_d;
      lb_data_q     <= lb_data_d;
    end
  end

  assign if_done_out     = if_done_q;
  assign if_data_out     = if_data_q;
  assign lb_done_out     = lb_done_q;
  assign lb_data_out     = lb_data_q;
  assign st_done_out     = st_done_q;
  assign mc_if_en_out    = mc_if_en_q;
  assign mc_lb_en_out    = mc_lb_en_q;
  assign mc_st_en_out    = mc_st_en_q;
  assign mc_addr_out     = mc_addr_q;
  assign mc_len_out      = mc_len_q;
  assign mc_data_out     = mc_data_q;
  assign timeout_err_out = timeout_err_q;
  // Direct clears pass straight through; deferred ones come from clear_fwd_q.
  assign mc_clear_out    = (rdy && clear_flag_in && !st_owned) || clear_fwd_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb -- directed self-checking bench for mem_arb (TIMEOUT_CYC = 4).
// Inputs change 1 ns after the rising edge; outputs are sampled there too
// (registered outputs) or 1 ns after driving (combinational mc_clear_out).
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst, rdy, clear_flag_in;
  logic        if_req_in, lb_req_in, st_req_in;
  logic [31:0] if_addr_in, lb_addr_in, st_addr_in, st_data_in;
  logic [1:0]  lb_len_in, st_len_in;
  logic        if_done_out, lb_done_out, st_done_out;
  logic [31:0] if_data_out, lb_data_out;
  logic        mc_if_en_out, mc_lb_en_out, mc_st_en_out;
  logic [31:0] mc_addr_out, mc_data_out;
  logic [1:0]  mc_len_out;
  logic        mc_clear_out;
  logic        mc_if_done_in, mc_lb_done_in, mc_st_done_in;
  logic [31:0] mc_data_in;
  logic        timeout_err_out;

  int checks   = 0;
  int failures = 0;

  logic [2:0] en, dn;  // {if, lb, st}
  assign en = {mc_if_en_out, mc_lb_en_out, mc_st_en_out};
  assign dn = {if_done_out, lb_done_out, st_done_out};

  mem_arb #(.TIMEOUT_CYC(8'd4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_flag_in(clear_flag_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .lb_req_in(lb_req_in), .lb_addr_in(lb_addr_in), .lb_len_in(lb_len_in),
    .st_req_in(st_req_in), .st_addr_in(st_addr_in), .st_len_in(st_len_in),
    .st_data_in(st_data_in),
    .if_done_out(if_done_out), .if_data_out(if_data_out),
    .lb_done_out(lb_done_out), .lb_data_out(lb_data_out),
    .st_done_out(st_done_out),
    .mc_if_en_out(mc_if_en_out), .mc_lb_en_out(mc_lb_en_out),
    .mc_st_en_out(mc_st_en_out),
    .mc_addr_out(mc_addr_out), .mc_len_out(mc_len_out),
    .mc_data_out(mc_data_out), .mc_clear_out(mc_clear_out),
    .mc_if_done_in(mc_if_done_in), .mc_lb_done_in(mc_lb_done_in),
    .mc_st_done_in(mc_st_done_in), .mc_data_in(mc_data_in),
    .timeout_err_out(timeout_err_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; clear_flag_in = 1'b0;
    if_req_in = 1'b0; if_addr_in = '0;
    lb_req_in = 1'b0; lb_addr_in = '0; lb_len_in = '0;
    st_req_in = 1'b0; st_addr_in = '0; st_len_in = '0; st_data_in = '0;
    mc_if_done_in = 1'b0; mc_lb_done_in = 1'b0; mc_st_done_in = 1'b0;
    mc_data_in = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    if_req_in = 1'b1; lb_req_in = 1'b1;
    tick(); tick();
    checks++; if ({en, dn, mc_clear_out, timeout_err_out} !== 8'h00) begin
      failures++; $display("FAIL reset_ctl got=%b exp=00000000", {en, dn, mc_clear_out, timeout_err_out}); end
    checks++; if ({mc_addr_out, mc_len_out, mc_data_out} !== 66'd0) begin
      failures++; $display("FAIL reset_mc got=%h/%h/%h exp=0", mc_addr_out, mc_len_out, mc_data_out); end
    checks++; if ({if_data_out, lb_data_out} !== 64'd0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0", if_data_out, lb_data_out); end
    rst = 1'b0; if_req_in = 1'b0; lb_req_in = 1'b0;
    tick(); tick();
    checks++; if (en !== 3'b000) begin
      failures++; $display("FAIL reset_idle_en got=%b exp=000", en); end
  endtask

  task automatic test_if_lb_rr();
    do_reset();
    if_req_in = 1'b1; if_addr_in = 32'h100;
    lb_req_in = 1'b1; lb_addr_in = 32'h200; lb_len_in = 2'd3;
    tick();  // ISSUE
    checks++; if (en !== 3'b100) begin
      failures++; $display("FAIL rr_first_if got=%b exp=100", en); end
    checks++; if ({mc_addr_out, mc_len_out} !== {32'h100, 2'd3}) begin
      failures++; $display("FAIL rr_if_fields got=%h/%h exp=100/3", mc_addr_out, mc_len_out); end
    tick();  // WAIT
    checks++; if (en !== 3'b000) begin
      failures++; $display("FAIL issue_one_cycle got=%b exp=000", en); end
    mc_if_done_in = 1'b1; mc_data_in = 32'hA5A5_0001;
    tick();
    mc_if_done_in = 1'b0;
    checks++; if ({dn, if_data_out} !== {3'b100, 32'hA5A5_0001}) begin
      failures++; $display("FAIL rr_if_done got=%b/%h exp=100/a5a50001", dn, if_data_out); end
    if_req_in = 1'b0;
    tick();
    checks++; if ({en, dn, mc_addr_out} !== {3'b010, 3'b000, 32'h200}) begin
      failures++; $display("FAIL rr_second_lb got=%b/%b/%h exp=010/000/200", en, dn, mc_addr_out); end
    tick();
    mc_lb_done_in = 1'b1; mc_data_in = 32'h5A5A_0002;
    tick();
    mc_lb_done_in = 1'b0;
    checks++; if ({dn, lb_data_out} !== {3'b010, 32'h5A5A_0002}) begin
      failures++; $display("FAIL rr_lb_done got=%b/%h exp=010/5a5a0002", dn, lb_data_out); end
    lb_req_in = 1'b0;
    tick();
    if_req_in = 1'b1; if_addr_in = 32'h300;  // IF alone, last grant becomes IF
    tick();
    checks++; if (en !== 3'b100) begin
      failures++; $display("FAIL rr_if_alone got=%b exp=100", en); end
    tick();
    mc_if_done_in = 1'b1;
    tick();
    mc_if_done_in = 1'b0; if_req_in = 1'b0;
    tick();
    if_req_in = 1'b1; if_addr_in = 32'h400;
    lb_req_in = 1'b1; lb_addr_in = 32'h500;
    tick();  // tie after an IF grant -> LB
    checks++; if ({en, mc_addr_out} !== {3'b010, 32'h500}) begin
      failures++; $display("FAIL rr_tie_lb got=%b/%h exp=010/500", en, mc_addr_out); end
  endtask

  task automatic test_st_priority();
    do_reset();
    st_req_in = 1'b1; st_addr_in = 32'h300; st_len_in = 2'd1; st_data_in = 32'hCAFE_F00D;
    if_req_in = 1'b1; if_addr_in = 32'h100;
    lb_req_in = 1'b1; lb_addr_in = 32'h200; lb_len_in = 2'd0;
    tick();
    checks++; if ({en, mc_addr_out, mc_len_out, mc_data_out} !== {3'b001, 32'h300, 2'd1, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL st_first got=%b/%h/%h/%h exp=001/300/1/cafef00d", en, mc_addr_out, mc_len_out, mc_data_out); end
    tick();
    mc_st_done_in = 1'b1;
    tick();
    mc_st_done_in = 1'b0;
    checks++; if (dn !== 3'b001) begin
      failures++; $display("FAIL st_done got=%b exp=001", dn); end
    st_req_in = 1'b0;
    tick();
    checks++; if ({en, mc_addr_out} !== {3'b100, 32'h100}) begin
      failures++; $display("FAIL st_then_if got=%b/%h exp=100/100", en, mc_addr_out); end
    tick();
    mc_if_done_in = 1'b1; mc_data_in = 32'h11;
    tick();
    mc_if_done_in = 1'b0; if_req_in = 1'b0;
    tick();
    checks++; if ({en, mc_addr_out, mc_len_out} !== {3'b010, 32'h200, 2'd0}) begin
      failures++; $display("FAIL st_then_lb got=%b/%h/%h exp=010/200/0", en, mc_addr_out, mc_len_out); end
    tick();
    mc_if_done_in = 1'b1; mc_st_done_in = 1'b1;  // not the owner
    tick();
    mc_if_done_in = 1'b0; mc_st_done_in = 1'b0;
    checks++; if (dn !== 3'b000) begin
      failures++; $display("FAIL foreign_done_ignored got=%b exp=000", dn); end
    mc_lb_done_in = 1'b1; mc_data_in = 32'h22;
    tick();
    mc_lb_done_in = 1'b0;
    checks++; if ({dn, lb_data_out} !== {3'b010, 32'h22}) begin
      failures++; $display("FAIL lb_after_foreign got=%b/%h exp=010/22", dn, lb_data_out); end
    lb_req_in = 1'b0;
  endtask

  task automatic test_lb_beef();
    do_reset();
    lb_req_in = 1'b1; lb_addr_in = 32'h1000; lb_len_in = 2'd1;
    tick();
    checks++; if ({en, mc_addr_out, mc_len_out} !== {3'b010, 32'h1000, 2'd1}) begin
      failures++; $display("FAIL beef_issue got=%b/%h/%h exp=010/1000/1", en, mc_addr_out, mc_len_out); end
    tick();
    mc_lb_done_in = 1'b1; mc_data_in = 32'h0000_BEEF;
    #1;
    checks++; if (lb_done_out !== 1'b0) begin
      failures++; $display("FAIL beef_latency got=%b exp=0", lb_done_out); end
    tick();
    mc_lb_done_in = 1'b0; mc_data_in = '0;
    checks++; if ({lb_done_out, lb_data_out} !== {1'b1, 32'h0000_BEEF}) begin
      failures++; $display("FAIL beef_done got=%b/%h exp=1/0000beef", lb_done_out, lb_data_out); end
    lb_req_in = 1'b0;
    tick();
    checks++; if ({lb_done_out, lb_data_out} !== {1'b0, 32'h0000_BEEF}) begin
      failures++; $display("FAIL beef_hold got=%b/%h exp=0/0000beef", lb_done_out, lb_data_out); end
  endtask

  task automatic test_clear_if();
    do_reset();
    if_req_in = 1'b1; if_addr_in = 32'h40;
    tick(); tick(); tick();  // WAIT, second cycle
    clear_flag_in = 1'b1;
    #1;
    checks++; if (mc_clear_out !== 1'b1) begin
      failures++; $display("FAIL clr_if_fwd got=%b exp=1", mc_clear_out); end
    tick();
    clear_flag_in = 1'b0;
    #1;
    checks++; if ({mc_clear_out, dn} !== 4'b0000) begin
      failures++; $display("FAIL clr_if_after got=%b/%b exp=0/000", mc_clear_out, dn); end
    tick();  // IF still held high but dropped by the clear
    checks++; if (en !== 3'b000) begin
      failures++; $display("FAIL clr_if_dropped got=%b exp=000", en); end
    if_req_in = 1'b0;
    tick();
    if_req_in = 1'b1; if_addr_in = 32'h44;
    tick();
    checks++; if ({en, mc_addr_out} !== {3'b100, 32'h44}) begin
      failures++; $display("FAIL clr_if_regrant got=%b/%h exp=100/44", en, mc_addr_out); end
    tick();
    mc_if_done_in = 1'b1; clear_flag_in = 1'b1;  // clear and done together
    #1;
    checks++; if (mc_clear_out !== 1'b1) begin
      failures++; $display("FAIL clr_done_fwd got=%b exp=1", mc_clear_out); end
    tick();
    mc_if_done_in = 1'b0; clear_flag_in = 1'b0;
    checks++; if (dn !== 3'b000) begin
      failures++; $display("FAIL clr_beats_done got=%b exp=000", dn); end
    if_req_in = 1'b0;
  endtask

  task automatic test_clear_st();
    do_reset();
    st_req_in = 1'b1; st_addr_in = 32'h500; st_len_in = 2'd3; st_data_in = 32'h1234_5678;
    tick(); tick();  // WAIT
    clear_flag_in = 1'b1;
    #1;
    checks++; if (mc_clear_out !== 1'b0) begin
      failures++; $display("FAIL clr_st_suppress got=%b exp=0", mc_clear_out); end
    tick();
    clear_flag_in = 1'b0; if_req_in = 1'b1; if_addr_in = 32'h60;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({mc_clear_out, en} !== 4'b0000) begin
        failures++; $display("FAIL clr_st_wait%0d got=%b/%b exp=0/000", i, mc_clear_out, en); end
      tick();
    end
    mc_st_done_in = 1'b1;
    #1;
    checks++; if (mc_clear_out !== 1'b0) begin
      failures++; $display("FAIL clr_st_at_mcdone got=%b exp=0", mc_clear_out); end
    tick();
    mc_st_done_in = 1'b0;
    checks++; if ({st_done_out, mc_clear_out} !== 2'b10) begin
      failures++; $display("FAIL clr_st_done got=%b/%b exp=1/0", st_done_out, mc_clear_out); end
    st_req_in = 1'b0;
    tick();
    checks++; if ({mc_clear_out, en} !== 4'b1000) begin
      failures++; $display("FAIL clr_st_forward got=%b/%b exp=1/000", mc_clear_out, en); end
    tick();
    checks++; if ({mc_clear_out, en} !== 4'b0000) begin
      failures++; $display("FAIL clr_st_after got=%b/%b exp=0/000", mc_clear_out, en); end
    if_req_in = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    if_req_in = 1'b1; if_addr_in = 32'h70;
    for (int i = 0; i < 5; i++) tick();  // ISSUE + 4 WAIT cycles
    checks++; if (timeout_err_out !== 1'b0) begin
      failures++; $display("FAIL to_before got=%b exp=0", timeout_err_out); end
    tick();
    checks++; if (timeout_err_out !== 1'b1) begin
      failures++; $display("FAIL to_set got=%b exp=1", timeout_err_out); end
    mc_if_done_in = 1'b1; mc_data_in = 32'h33;
    tick();
    mc_if_done_in = 1'b0; if_req_in = 1'b0;
    checks++; if ({if_done_out, if_data_out, timeout_err_out} !== {1'b1, 32'h33, 1'b1}) begin
      failures++; $display("FAIL to_still_waits got=%b/%h/%b exp=1/33/1", if_done_out, if_data_out, timeout_err_out); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (timeout_err_out !== 1'b1) begin
      failures++; $display("FAIL to_sticky got=%b exp=1", timeout_err_out); end
    rst = 1'b1;
    #1;
    checks++; if (timeout_err_out !== 1'b0) begin
      failures++; $display("FAIL to_rst_clear got=%b exp=0", timeout_err_out); end
    rst = 1'b0;
  endtask

  task automatic test_rdy();
    do_reset();
    lb_req_in = 1'b1; lb_addr_in = 32'h80; lb_len_in = 2'd0;
    tick();
    rdy = 1'b0;
    tick(); tick();
    checks++; if (en !== 3'b010) begin
      failures++; $display("FAIL rdy_hold_en got=%b exp=010", en); end
    rdy = 1'b1;
    tick();
    checks++; if (en !== 3'b000) begin
      failures++; $display("FAIL rdy_resume got=%b exp=000", en); end
    mc_lb_done_in = 1'b1; mc_data_in = 32'h77;
    tick();
    mc_lb_done_in = 1'b0; rdy = 1'b0; lb_req_in = 1'b0;
    tick();
    checks++; if ({lb_done_out, lb_data_out} !== {1'b1, 32'h77}) begin
      failures++; $display("FAIL rdy_hold_done got=%b/%h exp=1/77", lb_done_out, lb_data_out); end
    rdy = 1'b1;
    tick();
    checks++; if ({lb_done_out, lb_data_out} !== {1'b0, 32'h77}) begin
      failures++; $display("FAIL rdy_done_end got=%b/%h exp=0/77", lb_done_out, lb_data_out); end
  endtask

  initial begin
    test_reset();
    test_if_lb_rr();
    test_st_priority();
    test_lb_beef();
    test_clear_if();
    test_clear_st();
    test_timeout();
    test_rdy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
